dm633_scanout: RTL and testbench
================================

// Module: dm633_scanout
// PURPOSE
//  Frame scanout sequencer for the LED board chain. Drives the framebuffer read port, serialises
//  every 12-bit channel onto the daisy-chained DM633 drivers (2 per ledboard, 16 ch each), then
//  pulses latch. One frame is sent per accepted start; the write side of the framebuffer is untouched.
// PARAMETERS
//  c_ledboards   30                       ledboards in the chain
//  c_channels    c_ledboards*32           channels (framebuffer words) per frame
//  c_addr_w      $clog2(c_channels)       framebuffer address width
//  c_bpc         12                       bits per channel (PWM width)
//  c_clkdiv      2                        i_clk cycles per o_dck half-period (>=1)
//  c_lat_cycles  4                        i_clk cycles o_lat is held high (>=1)
// PORTS
//  i_clk     in   1         system clock; all state on rising edge
//  i_rst     in   1         reset, asynchronous, active-high
//  i_start   in   1         frame request; sampled only in IDLE
//  o_busy    out  1         high from the cycle after start is accepted until o_done
//  o_done    out  1         one-cycle pulse at end of frame
//  o_raddr   out  c_addr_w  framebuffer read address (registered)
//  i_rdata   in   c_bpc     framebuffer read data, valid 1 cycle after o_raddr
//  o_dck     out  1         DM633 serial clock; drivers sample o_sin on rising edge
//  o_sin     out  1         DM633 serial data
//  o_lat     out  1         DM633 latch
// BEHAVIOUR
//  Reset (async): state IDLE; o_busy, o_done, o_raddr, o_dck, o_sin, o_lat all 0, effective immediately.
//  Order: channel c_channels-1 first, down to channel 0 (first bit shifted lands in the far driver);
//   each word MSB first.
//  States:
//   IDLE  : o_busy=0. i_start=1 -> o_raddr<=c_channels-1, o_busy<=1, -> FETCH.
//   FETCH : 1 cycle, address presented; framebuffer registers data -> LOAD.
//   LOAD  : 1 cycle; shift reg <= i_rdata, bit count <= 0 -> SHIFT.
//   SHIFT : per bit, o_sin = shift MSB, o_dck low c_clkdiv cycles then high c_clkdiv cycles.
//           o_sin changes only while o_dck is low, held stable across the high phase.
//           After the high phase: shift left, count+1. After c_bpc bits:
//           o_raddr==0 -> LATCH, else o_raddr<=o_raddr-1 -> FETCH.
//   LATCH : o_dck=0, o_lat=1 for exactly c_lat_cycles cycles -> IDLE with o_done=1
//           and o_busy=0 in that same cycle.
//  o_dck is 0 in IDLE, FETCH, LOAD and LATCH. o_sin is 0 outside SHIFT.
//  Frame length (start-accept edge to o_done cycle) = c_channels*(2+2*c_clkdiv*c_bpc) + c_lat_cycles.
//  Exactly c_channels*c_bpc o_dck rising edges and one o_lat pulse per frame.
//  i_start while busy: ignored, not queued. i_start high in the o_done cycle: accepted, so back-to-back
//   frames are separated by that single IDLE cycle.
//  Reset mid-frame: abort, no o_lat/o_done pulse; the next start sends a complete frame from c_channels-1.
//  Counters: bit count width $clog2(c_bpc+1), divider width $clog2(c_clkdiv+1); no wrap on o_raddr
//   (decrement stops at 0).
// TESTING  (bench: real framebuffer model, c_ledboards=1 -> 32 ch, c_bpc=12, c_clkdiv=1, c_lat_cycles=2 unless noted)
//  1 Assert i_rst mid-cycle with outputs toggling -> all outputs 0 before the next clock edge; o_busy stays 0 with no start.
//  2 Memory word[k] = 12'h800|k (word[31]=12'h81F); pulse start -> 384 bits captured on o_dck rise equal
//    word31..word0 MSB first, first bits 1,0,0,0,0,0,0,1,1,1,1,1.
//  3 Single start -> o_done exactly 834 cycles after the accept edge; o_lat high 2 cycles with o_dck=0; 384 o_dck rises.
//  4 Pulse start again at cycle 100 of a frame -> ignored, single frame. Hold start high -> frames repeat with 1 idle cycle.
//  5 Assert i_rst during bit 100 -> no o_lat, no o_done. New start -> full, correct 384-bit frame.
//  6 c_clkdiv=3 -> o_dck high 3 and low 3 cycles, o_sin never changes while o_dck=1, frame = 32*74+2 = 2370 cycles.

Source files
------------

// File: rtl/dm633_scanout.sv
// Frame scanout sequencer: reads the framebuffer top-down and shifts every channel
// MSB-first onto a DM633 daisy chain, then pulses latch once per accepted start.
module dm633_scanout #(
  parameter int c_ledboards  = 30,
  parameter int c_channels   = c_ledboards * 32,
  parameter int c_addr_w     = $clog2(c_channels),
  parameter int c_bpc        = 12,
  parameter int c_clkdiv     = 2,
  parameter int c_lat_cycles = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  output logic                o_dck,
  output logic                o_sin,
  output logic                o_lat
);

  localparam int CNT_W = $clog2(c_bpc + 1);
  localparam int DIV_W = $clog2(c_clkdiv + 1);
  localparam int LAT_W = $clog2(c_lat_cycles + 1);

  localparam logic [CNT_W-1:0]    BIT_LAST = CNT_W'(c_bpc - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(c_clkdiv - 1);
  localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(c_lat_cycles - 1);
  localparam logic [c_addr_w-1:0] ADDR_TOP = c_addr_w'(c_channels - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [c_addr_w-1:0] raddr_q;
  logic                dck_q;
  logic                sin_q;
  logic                lat_q;
  logic [c_bpc-1:0]    shift_q;
  logic [CNT_W-1:0]    bit_q;
  logic [DIV_W-1:0]    div_q;
  logic                high_q;
  logic [LAT_W-1:0]    latcnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      raddr_q  <= '0;
      dck_q    <= 1'b0;
      sin_q    <= 1'b0;
      lat_q    <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      high_q   <= 1'b0;
      latcnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            raddr_q <= ADDR_TOP;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q <= i_rdata;
          bit_q   <= '0;
          div_q   <= '0;
          high_q  <= 1'b0;
          sin_q   <= i_rdata[c_bpc-1];
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!high_q) begin
              high_q <= 1'b1;
              dck_q  <= 1'b1;
            end else begin
              // o_sin is updated together with the falling o_dck edge, so it
              // is already settled for the whole high phase of the next bit.
              high_q  <= 1'b0;
              dck_q   <= 1'b0;
              shift_q <= shift_q << 1;
              bit_q   <= bit_q + 1'b1;
              if (bit_q != BIT_LAST) begin
                sin_q <= shift_q[c_bpc-2];
              end else begin
                sin_q <= 1'b0;
                if (raddr_q == '0) begin
                  lat_q    <= 1'b1;
                  latcnt_q <= '0;
                  state_q  <= S_LATCH;
                end else begin
                  raddr_q <= raddr_q - 1'b1;
                  state_q <= S_FETCH;
                end
              end
            end
          end
        end
        S_LATCH: begin
          if (latcnt_q == LAT_LAST) begin
            lat_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            latcnt_q <= latcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_raddr = raddr_q;
  assign o_dck   = dck_q;
  assign o_sin   = sin_q;
  assign o_lat   = lat_q;

endmodule

// File: tb/tb_dm633_scanout.sv
// Bench for dm633_scanout: two instances (o_dck divider 1 and 3), each with a registered
// framebuffer model; a waveform monitor feeds counters checked against a spec-level model.
module tb_dm633_scanout;

  localparam int C   = 32;
  localparam int BPC = 12;
  localparam int LAT = 2;
  localparam int MAXB = 4096;

  logic        clk;
  logic        rst;
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic        dck   [2];
  logic        sin   [2];
  logic        lat   [2];
  logic [4:0]  raddr [2];
  logic [11:0] rdata [2];
  logic [11:0] mem   [2][C];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  logic mon_en;

  // monitor state, per instance
  int   rises [2], lat_cyc [2], lat_dck_bad [2], done_cnt [2], sin_bad [2];
  int   hi_ok [2], hi_bad [2], lo_cd [2], lo_cd2 [2], lo_bad [2], run [2];
  int   start_cyc [2], last_done [2], nbits [2], nlens [2], ngaps [2];
  bit   seen_rise [2];
  logic pdck [2], psin [2], pbusy [2];
  bit   bits_a [2][MAXB];
  int   lens_a [2][8];
  int   gaps_a [2][8];

  dm633_scanout #(
    .c_ledboards(1), .c_bpc(BPC), .c_clkdiv(1), .c_lat_cycles(LAT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_raddr(raddr[0]), .i_rdata(rdata[0]), .o_dck(dck[0]), .o_sin(sin[0]), .o_lat(lat[0])
  );

  dm633_scanout #(
    .c_ledboards(1), .c_bpc(BPC), .c_clkdiv(3), .c_lat_cycles(LAT)
  ) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_raddr(raddr[1]), .i_rdata(rdata[1]), .o_dck(dck[1]), .o_sin(sin[1]), .o_lat(lat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int j = 0; j < 2; j++) rdata[j] <= mem[j][raddr[j]];
  end

  function automatic int cd_of(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  function automatic int frame_len(input int cd);
    return C * (2 + 2 * cd * BPC) + LAT;
  endfunction

  // Expected serial stream: channels C-1..0, each word MSB first, repeating per frame.
  function automatic int bit_mism(input int j, input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++) begin
      int ch;
      int b;
      logic [11:0] w;
      ch = C - 1 - ((i % (C * BPC)) / BPC);
      b  = BPC - 1 - (i % BPC);
      w  = mem[j][ch];
      if (bits_a[j][i] !== w[b]) m++;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!mon_en) begin
        rises[j] = 0; lat_cyc[j] = 0; lat_dck_bad[j] = 0; done_cnt[j] = 0; sin_bad[j] = 0;
        hi_ok[j] = 0; hi_bad[j] = 0; lo_cd[j] = 0; lo_cd2[j] = 0; lo_bad[j] = 0; run[j] = 0;
        start_cyc[j] = 0; last_done[j] = 0; nbits[j] = 0; nlens[j] = 0; ngaps[j] = 0;
        seen_rise[j] = 1'b0;
        pdck[j] = dck[j]; psin[j] = sin[j]; pbusy[j] = busy[j];
      end else begin
        if (dck[j] === 1'b1 && pdck[j] === 1'b0) begin
          rises[j]++;
          if (nbits[j] < MAXB) begin
            bits_a[j][nbits[j]] = sin[j];
            nbits[j]++;
          end
          if (seen_rise[j]) begin
            if (run[j] == cd_of(j)) lo_cd[j]++;
            else if (run[j] == cd_of(j) + 2) lo_cd2[j]++;
            else lo_bad[j]++;
          end
          seen_rise[j] = 1'b1;
        end
        if (dck[j] === 1'b0 && pdck[j] === 1'b1) begin
          if (run[j] == cd_of(j)) hi_ok[j]++;
          else hi_bad[j]++;
        end
        if (dck[j] !== pdck[j]) run[j] = 1;
        else run[j]++;
        if (dck[j] === 1'b1 && pdck[j] === 1'b1 && sin[j] !== psin[j]) sin_bad[j]++;
        if (lat[j] === 1'b1) begin
          lat_cyc[j]++;
          if (dck[j] !== 1'b0) lat_dck_bad[j]++;
        end
        if (busy[j] === 1'b1 && pbusy[j] !== 1'b1) begin
          if (done_cnt[j] > 0 && ngaps[j] < 8) begin
            gaps_a[j][ngaps[j]] = cyc - last_done[j];
            ngaps[j]++;
          end
          start_cyc[j] = cyc;
        end
        if (busy[j] !== 1'b1) seen_rise[j] = 1'b0;
        if (done[j] === 1'b1) begin
          done_cnt[j]++;
          if (nlens[j] < 8) begin
            lens_a[j][nlens[j]] = cyc - start_cyc[j];
            nlens[j]++;
          end
          last_done[j] = cyc;
        end
        pdck[j] = dck[j]; psin[j] = sin[j]; pbusy[j] = busy[j];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_en = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic pulse_start(input int j);
    start[j] = 1'b1;
    tick();
    start[j] = 1'b0;
  endtask

  task automatic wait_done(input int j, input int n, input int budget);
    for (int i = 0; i < budget && done_cnt[j] < n; i++) tick();
    tick();
  endtask

  task automatic randomize_mem(input int j);
    for (int k = 0; k < C; k++) mem[j][k] = 12'($urandom);
  endtask

  initial begin
    int seen;
    logic [11:0] first12;
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mon_en = 1'b0;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < C; k++) mem[j][k] = '0;
    repeat (3) tick();
    chk("rst_busy", busy[0], 0);
    chk("rst_dck", dck[0], 0);
    rst = 1'b0;
    tick();

    // 1: asynchronous reset mid-cycle while shifting
    for (int k = 0; k < C; k++) mem[0][k] = 12'hFFF;
    clear_mon();
    pulse_start(0);
    repeat (150) tick();
    for (int i = 0; i < 50 && dck[0] !== 1'b1; i++) tick();
    chk("t1_pre_busy", busy[0], 1);
    chk("t1_pre_dck", dck[0], 1);
    chk("t1_pre_sin", sin[0], 1);
    rst = 1'b1;
    #1;
    chk("t1_busy", busy[0], 0);
    chk("t1_done", done[0], 0);
    chk("t1_raddr", raddr[0], 0);
    chk("t1_dck", dck[0], 0);
    chk("t1_sin", sin[0], 0);
    chk("t1_lat", lat[0], 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("t1_idle_busy", busy[0], 0);
    chk("t1_no_done", done_cnt[0], 0);

    // 2/3: known pattern, single frame
    for (int k = 0; k < C; k++) mem[0][k] = 12'h800 | 12'(k);
    clear_mon();
    pulse_start(0);
    wait_done(0, 1, 2000);
    chk("t2_done_cnt", done_cnt[0], 1);
    chk("t2_nbits", nbits[0], C * BPC);
    chk("t2_bits", bit_mism(0, C * BPC), 0);
    for (int i = 0; i < 12; i++) first12[11-i] = bits_a[0][i];
    chk("t2_first12", first12, 12'h81F);
    chk("t3_len", lens_a[0][0], frame_len(1));
    chk("t3_lat_cyc", lat_cyc[0], LAT);
    chk("t3_lat_dck", lat_dck_bad[0], 0);
    chk("t3_rises", rises[0], C * BPC);
    chk("t3_sin_stable", sin_bad[0], 0);
    chk("t3_hi_bad", hi_bad[0], 0);

    // 4a: start while busy is ignored
    randomize_mem(0);
    clear_mon();
    pulse_start(0);
    repeat (99) tick();
    pulse_start(0);
    wait_done(0, 1, 2000);
    repeat (900) tick();
    chk("t4_done_cnt", done_cnt[0], 1);
    chk("t4_rises", rises[0], C * BPC);
    chk("t4_bits", bit_mism(0, C * BPC), 0);
    chk("t4_idle", busy[0], 0);

    // 4b: start held high -> back-to-back frames with one idle cycle
    randomize_mem(0);
    clear_mon();
    start[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 4000 && seen < 3; i++) begin
      tick();
      if (done[0] === 1'b1) seen++;
    end
    start[0] = 1'b0;
    repeat (5) tick();
    chk("t4b_done_cnt", done_cnt[0], 3);
    chk("t4b_rises", rises[0], 3 * C * BPC);
    chk("t4b_bits", bit_mism(0, 3 * C * BPC), 0);
    for (int f = 0; f < 3; f++) chk($sformatf("t4b_len%0d", f), lens_a[0][f], frame_len(1));
    chk("t4b_ngaps", ngaps[0], 2);
    for (int g = 0; g < 2; g++) chk($sformatf("t4b_gap%0d", g), gaps_a[0][g], 1);
    chk("t4b_lat_cyc", lat_cyc[0], 3 * LAT);
    chk("t4b_idle", busy[0], 0);

    // 5: reset during bit 100 aborts; next frame is complete
    randomize_mem(0);
    clear_mon();
    pulse_start(0);
    for (int i = 0; i < 2000 && rises[0] < 100; i++) tick();
    chk("t5_at_bit100", rises[0], 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (1000) tick();
    chk("t5_no_lat", lat_cyc[0], 0);
    chk("t5_no_done", done_cnt[0], 0);
    chk("t5_idle", busy[0], 0);
    clear_mon();
    pulse_start(0);
    wait_done(0, 1, 2000);
    chk("t5_done_cnt", done_cnt[0], 1);
    chk("t5_rises", rises[0], C * BPC);
    chk("t5_bits", bit_mism(0, C * BPC), 0);
    chk("t5_len", lens_a[0][0], frame_len(1));
    chk("t5_lat_cyc", lat_cyc[0], LAT);

    // 6: divider of 3
    randomize_mem(1);
    clear_mon();
    pulse_start(1);
    wait_done(1, 1, 5000);
    chk("t6_done_cnt", done_cnt[1], 1);
    chk("t6_len", lens_a[1][0], frame_len(3));
    chk("t6_rises", rises[1], C * BPC);
    chk("t6_hi_ok", hi_ok[1], C * BPC);
    chk("t6_hi_bad", hi_bad[1], 0);
    chk("t6_lo_cd", lo_cd[1], C * (BPC - 1));
    chk("t6_lo_word", lo_cd2[1], C - 1);
    chk("t6_lo_bad", lo_bad[1], 0);
    chk("t6_sin_stable", sin_bad[1], 0);
    chk("t6_bits", bit_mism(1, C * BPC), 0);
    chk("t6_lat_cyc", lat_cyc[1], LAT);
    chk("t6_lat_dck", lat_dck_bad[1], 0);
    chk("t6_other_idle", done_cnt[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
